mem_ctrl: RTL and testbench

//  Arbitrates the single byte-wide RAM/IO port between instruction fetch and the load/store buffer.

---
 rtl/mem_ctrl.sv | 224 ++++++++++++++++++++++
 tb/tb_mem_ctrl.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_ctrl.sv
// mem_ctrl: arbitrates the byte-wide RAM/IO port between instruction fetch
// and the load/store buffer. Each grant becomes a run of 1/2/4 byte reads
// or writes. Read bytes are packed little-endian into a 32-bit word.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | no transfer in flight; round-robin grant of the next request
// RD    | reading n bytes; mem_din captured one cycle after each address
// WR    | writing n bytes; IO writes stall while io_buffer_full is high
module mem_ctrl #(
  parameter logic [31:0] IO_BOUND = 32'h30000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        clear,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_done,
  output logic [31:0] if_data,
  input  logic        ls_req,
  input  logic        ls_wr,
  input  logic [1:0]  ls_size,
  input  logic [31:0] ls_addr,
  input  logic [31:0] ls_wdata,
  output logic        ls_done,
  output logic [31:0] ls_rdata,
  input  logic [7:0]  mem_din,
  output logic [7:0]  mem_dout,
  output logic [31:0] mem_a,
  output logic        mem_wr,
  input  logic        io_buffer_full
);

  typedef enum logic [1:0] {IDLE, RD, WR} state_t;

  state_t      state_q, state_d;
  logic        last_ls_q, last_ls_d;
  logic        cur_ls_q, cur_ls_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [2:0]  n_q, n_d;
  logic [2:0]  k_q, k_d;
  logic [31:0] acc_q, acc_d;
  logic        if_done_q, if_done_d;
  logic [31:0] if_data_q, if_data_d;
  logic        ls_done_q, ls_done_d;
  logic [31:0] ls_rdata_q, ls_rdata_d;
  logic [31:0] mem_a_q, mem_a_d;
  logic [7:0]  mem_dout_q, mem_dout_d;
  logic        mem_wr_q, mem_wr_d;
  logic        rdy_prev;

  logic [2:0]  ls_n;
  logic        if_elig;
  logic        ls_elig;
  logic        grant_ls;
  logic [2:0]  k_inc;
  logic [31:0] addr_k;
  logic [31:0] acc_cap;
  logic [7:0]  wbyte;

  // Decode helpers: eligibility, round-robin pick, current byte address/data.
  always_comb begin
    ls_n     = (ls_size == 2'd0) ? 3'd1 : ((ls_size == 2'd1) ? 3'd2 : 3'd4);
    if_elig  = if_req && !if_done_q;
    ls_elig  = ls_req && !ls_done_q;
    grant_ls = ls_elig && (!if_elig || !last_ls_q);
    k_inc    = k_q + 3'd1;
    addr_k   = addr_q + {29'd0, k_q};
    acc_cap  = acc_q | ({24'd0, mem_din} << {k_q[1:0], 3'b000});
    wbyte    = wdata_q[{k_q[1:0], 3'b000} +: 8];
  end

  // Next-state and registered-output logic; only applied on rdy = 1 edges.
  always_comb begin
    state_d    = state_q;
    last_ls_d  = last_ls_q;
    cur_ls_d   = cur_ls_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    n_d        = n_q;
    k_d        = k_q;
    acc_d      = acc_q;
    if_done_d  = 1'b0;
    if_data_d  = if_data_q;
    ls_done_d  = 1'b0;
    ls_rdata_d = ls_rdata_q;
    mem_a_d    = mem_a_q;
    mem_dout_d = mem_dout_q;
    mem_wr_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (!clear && (if_elig || ls_elig)) begin
          last_ls_d = grant_ls;
          cur_ls_d  = grant_ls;
          k_d       = 3'd0;
          acc_d     = 32'd0;
          if (grant_ls) begin
            addr_d  = ls_addr;
            wdata_d = ls_wdata;
            n_d     = ls_n;
            mem_a_d = ls_addr;
            if (ls_wr) begin
              state_d = WR;
              // The grant edge already issues byte 0 unless the IO buffer is full.
              if (!(io_buffer_full && ls_addr >= IO_BOUND)) begin
                mem_wr_d   = 1'b1;
                mem_dout_d = ls_wdata[7:0];
                k_d        = 3'd1;
              end
            end else begin
              state_d = RD;
            end
          end else begin
            addr_d  = if_addr;
            n_d     = 3'd4;
            mem_a_d = if_addr;
            state_d = RD;
          end
        end
      end

      RD: begin
        if (clear) begin
          state_d = IDLE;
          mem_a_d = 32'd0;
        end else if (rdy_prev) begin
          acc_d = acc_cap;
          k_d   = k_inc;
          if (k_inc == n_q) begin
            state_d = IDLE;
            mem_a_d = 32'd0;
            if (cur_ls_q) begin
              ls_done_d  = 1'b1;
              ls_rdata_d = acc_cap;
            end else begin
              if_done_d = 1'b1;
              if_data_d = acc_cap;
            end
          end else begin
            mem_a_d = addr_k + 32'd1;
          end
        end else begin
          // First edge after a freeze: mem_din may be stale, so replay the address.
          mem_a_d = addr_k;
        end
      end

      WR: begin
        if (k_q == n_q) begin
          state_d   = IDLE;
          mem_a_d   = 32'd0;
          ls_done_d = 1'b1;
        end else if (io_buffer_full && addr_k >= IO_BOUND) begin
          mem_a_d = addr_k;
        end else begin
          mem_wr_d   = 1'b1;
          mem_a_d    = addr_k;
          mem_dout_d = wbyte;
          k_d        = k_inc;
        end
      end

      default: begin
        state_d = IDLE;
        mem_a_d = 32'd0;
      end
    endcase
  end

  // State and output registers; everything holds while rdy is low.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      last_ls_q  <= 1'b0;
      cur_ls_q   <= 1'b0;
      addr_q     <= 32'd0;
      wdata_q    <= 32'd0;
      n_q        <= 3'd0;
      k_q        <= 3'd0;
      acc_q      <= 32'd0;
      if_done_q  <= 1'b0;
      if_data_q  <= 32'd0;
      ls_done_q  <= 1'b0;
      ls_rdata_q <= 32'd0;
      mem_a_q    <= 32'd0;
      mem_dout_q <= 8'd0;
      mem_wr_q   <= 1'b0;
    end else if (rdy) begin
      state_q    <= state_d;
      last_ls_q  <= last_ls_d;
      cur_ls_q   <= cur_ls_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      n_q        <= n_d;
      k_q        <= k_d;
      acc_q      <= acc_d;
      if_done_q  <= if_done_d;
      if_data_q  <= if_data_d;
      ls_done_q  <= ls_done_d;
      ls_rdata_q <= ls_rdata_d;
      mem_a_q    <= mem_a_d;
      mem_dout_q <= mem_dout_d;
      mem_wr_q   <= mem_wr_d;
    end
  end

  // Remembers whether the previous cycle was enabled; gates read capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) rdy_prev <= 1'b0;
    else     rdy_prev <= rdy;
  end

  assign if_done  = if_done_q;
  assign if_data  = if_data_q;
  assign ls_done  = ls_done_q;
  assign ls_rdata = ls_rdata_q;
  assign mem_a    = mem_a_q;
  assign mem_dout = mem_dout_q;
  assign mem_wr   = mem_wr_q & rdy;

endmodule

// File: tb/tb_mem_ctrl.sv
// tb_mem_ctrl: directed stimulus for mem_ctrl with a queue-based scoreboard.
// Stimulus pushes expected writes and done responses; a negedge monitor pops
// and compares them whenever the DUT writes or pulses a done.
module tb_mem_ctrl;

  logic        clk, rst, rdy, clear;
  logic        if_req, if_done;
  logic [31:0] if_addr, if_data;
  logic        ls_req, ls_wr, ls_done;
  logic [1:0]  ls_size;
  logic [31:0] ls_addr, ls_wdata, ls_rdata;
  logic [7:0]  mem_din, mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr, io_buffer_full;

  logic [7:0] ram [0:1023];
  assign mem_din = ram[mem_a[9:0]];

  typedef struct {
    logic        is_ls;
    logic        chkd;
    logic [31:0] data;
  } resp_t;

  resp_t       resp_q[$];
  logic [39:0] wr_q[$];

  int vectors = 0;
  int miscompares = 0;

  mem_ctrl dut (
    .clk(clk), .rst(rst), .rdy(rdy), .clear(clear),
    .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_data(if_data),
    .ls_req(ls_req), .ls_wr(ls_wr), .ls_size(ls_size), .ls_addr(ls_addr),
    .ls_wdata(ls_wdata), .ls_done(ls_done), .ls_rdata(ls_rdata),
    .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
    .io_buffer_full(io_buffer_full)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic flag(input string name);
    vectors++;
    miscompares++;
    $display("FAIL %s", name);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_resp(input logic is_ls, input logic chkd, input logic [31:0] data);
    resp_t r;
    r.is_ls = is_ls;
    r.chkd  = chkd;
    r.data  = data;
    resp_q.push_back(r);
  endtask

  task automatic wait_if(input int budget);
    int i = 0;
    while (!if_done && i < budget) begin
      tick();
      i++;
    end
    if (!if_done) flag("if_done_timeout");
  endtask

  task automatic wait_ls(input int budget);
    int i = 0;
    while (!ls_done && i < budget) begin
      tick();
      i++;
    end
    if (!ls_done) flag("ls_done_timeout");
  endtask

  // Scoreboard monitor: checks every write and every done against the queues.
  initial begin
    resp_t e;
    logic [39:0] w;
    forever begin
      @(negedge clk);
      if (!rst && rdy) begin
        if (if_done && ls_done) flag("both_done_same_cycle");
        if (mem_wr) begin
          if (wr_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL unexpected_write: addr %h data %h", mem_a, mem_dout);
          end else begin
            w = wr_q.pop_front();
            chk("wr_addr", mem_a, w[39:8]);
            chk("wr_data", {24'd0, mem_dout}, {24'd0, w[7:0]});
          end
        end
        if (if_done || ls_done) begin
          if (resp_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL unexpected_done: if_done %b ls_done %b", if_done, ls_done);
          end else begin
            e = resp_q.pop_front();
            chk("done_src_ls", {31'd0, ls_done}, {31'd0, e.is_ls});
            if (e.chkd) chk("done_data", ls_done ? ls_rdata : if_data, e.data);
          end
        end
      end
    end
  end

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_if_done"},  {31'd0, if_done}, 32'd0);
    chk({tag, "_ls_done"},  {31'd0, ls_done}, 32'd0);
    chk({tag, "_if_data"},  if_data, 32'd0);
    chk({tag, "_ls_rdata"}, ls_rdata, 32'd0);
    chk({tag, "_mem_a"},    mem_a, 32'd0);
    chk({tag, "_mem_dout"}, {24'd0, mem_dout}, 32'd0);
    chk({tag, "_mem_wr"},   {31'd0, mem_wr}, 32'd0);
  endtask

  initial begin
    int n_if, n_ls, cyc;
    for (int i = 0; i < 1024; i++) ram[i] = 8'(i) ^ 8'hA5;
    ram[10'h100] = 8'h13;
    ram[10'h101] = 8'h05;
    ram[10'h102] = 8'h00;
    ram[10'h103] = 8'h00;

    rst = 1'b1; rdy = 1'b1; clear = 1'b0; io_buffer_full = 1'b0;
    if_req = 1'b0; if_addr = 32'd0;
    ls_req = 1'b0; ls_wr = 1'b0; ls_size = 2'd0; ls_addr = 32'd0; ls_wdata = 32'd0;

    // Reset state
    @(negedge clk);
    @(negedge clk);
    chk_reset_outputs("reset");
    @(posedge clk); #1;
    rst = 1'b0;
    tick();

    // Both requesting from reset: LSB first, then strict alternation
    if_addr = 32'h100;
    ls_wr = 1'b0; ls_size = 2'd1; ls_addr = 32'h10;
    for (int i = 0; i < 3; i++) begin
      push_resp(1'b1, 1'b1, 32'h0000B4B5);
      push_resp(1'b0, 1'b1, 32'h00000513);
    end
    if_req = 1'b1; ls_req = 1'b1;
    n_if = 0; n_ls = 0; cyc = 0;
    while (n_if < 3 && cyc < 300) begin
      tick();
      cyc++;
      if (ls_done) begin
        n_ls++;
        if (n_ls == 3) ls_req = 1'b0;
      end
      if (if_done) begin
        n_if++;
        if (n_if == 3) if_req = 1'b0;
      end
    end
    if (n_if < 3) flag("alternation_timeout");
    if_req = 1'b0; ls_req = 1'b0;
    tick();

    // Instruction fetch of 0x100 with address sequence and 4-cycle latency
    push_resp(1'b0, 1'b1, 32'h00000513);
    if_addr = 32'h100; if_req = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("t1_mem_a", mem_a, 32'h100 + k);
      chk("t1_no_done_yet", {31'd0, if_done}, 32'd0);
    end
    tick();
    chk("t1_if_done", {31'd0, if_done}, 32'd1);
    chk("t1_mem_a_idle", mem_a, 32'd0);
    if_req = 1'b0;
    tick();

    // Half-word store 0xABCD to 0x2000
    wr_q.push_back({32'h2000, 8'hCD});
    wr_q.push_back({32'h2001, 8'hAB});
    push_resp(1'b1, 1'b0, 32'd0);
    ls_wr = 1'b1; ls_size = 2'd1; ls_addr = 32'h2000; ls_wdata = 32'h0000ABCD;
    ls_req = 1'b1;
    wait_ls(20);
    chk("t2_mem_wr_done", {31'd0, mem_wr}, 32'd0);
    ls_req = 1'b0;
    tick();
    chk("t2_mem_wr_after", {31'd0, mem_wr}, 32'd0);

    // IO store with buffer full for three cycles
    wr_q.push_back({32'h30000, 8'h41});
    push_resp(1'b1, 1'b0, 32'd0);
    ls_wr = 1'b1; ls_size = 2'd0; ls_addr = 32'h30000; ls_wdata = 32'h00000041;
    io_buffer_full = 1'b1;
    ls_req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t4_stall_no_wr", {31'd0, mem_wr}, 32'd0);
    end
    io_buffer_full = 1'b0;
    tick();
    chk("t4_write_issued", {31'd0, mem_wr}, 32'd1);
    wait_ls(20);
    ls_req = 1'b0;
    tick();

    // Word load at 0x40 aborted by clear after two bytes
    ls_wr = 1'b0; ls_size = 2'd2; ls_addr = 32'h40;
    ls_req = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("t5_rd_addr", mem_a, 32'h40 + k);
    end
    clear = 1'b1; ls_req = 1'b0;
    tick();
    chk("t5_abort_mem_a", mem_a, 32'd0);
    chk("t5_abort_no_done", {31'd0, ls_done}, 32'd0);
    clear = 1'b0;
    tick();
    chk("t5_abort_no_late_done", {31'd0, ls_done}, 32'd0);

    // Byte load where clear lands on the completing edge: done suppressed
    ls_size = 2'd0; ls_addr = 32'h40;
    ls_req = 1'b1;
    tick();
    clear = 1'b1; ls_req = 1'b0;
    tick();
    chk("t5_done_suppressed", {31'd0, ls_done}, 32'd0);
    chk("t5_supp_mem_a", mem_a, 32'd0);
    clear = 1'b0;
    tick();

    // Request during clear is ignored; afterwards a clean word load
    push_resp(1'b1, 1'b1, 32'hE6E7E4E5);
    ls_size = 2'd2; ls_addr = 32'h40;
    ls_req = 1'b1; clear = 1'b1;
    tick();
    chk("t5_clear_idle_no_grant", mem_a, 32'd0);
    clear = 1'b0;
    wait_ls(20);
    ls_req = 1'b0;
    tick();

    // Word store survives a clear pulse
    wr_q.push_back({32'h2100, 8'h44});
    wr_q.push_back({32'h2101, 8'h33});
    wr_q.push_back({32'h2102, 8'h22});
    wr_q.push_back({32'h2103, 8'h11});
    push_resp(1'b1, 1'b0, 32'd0);
    ls_wr = 1'b1; ls_size = 2'd2; ls_addr = 32'h2100; ls_wdata = 32'h11223344;
    ls_req = 1'b1;
    tick();
    tick();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    wait_ls(20);
    ls_req = 1'b0;
    tick();

    // rdy low for two cycles mid word fetch: address replayed, data intact
    push_resp(1'b0, 1'b1, 32'h00000513);
    if_addr = 32'h100; if_req = 1'b1;
    tick();
    chk("t6_mem_a0", mem_a, 32'h100);
    tick();
    chk("t6_mem_a1", mem_a, 32'h101);
    rdy = 1'b0;
    tick();
    chk("t6_frozen_mem_a", mem_a, 32'h101);
    chk("t6_frozen_no_wr", {31'd0, mem_wr}, 32'd0);
    tick();
    chk("t6_frozen_mem_a2", mem_a, 32'h101);
    rdy = 1'b1;
    tick();
    chk("t6_replay_mem_a", mem_a, 32'h101);
    tick();
    chk("t6_resume_mem_a", mem_a, 32'h102);
    wait_if(20);
    if_req = 1'b0;
    tick();

    // Async reset in the middle of a word store
    wr_q.push_back({32'h2200, 8'hEF});
    ls_wr = 1'b1; ls_size = 2'd2; ls_addr = 32'h2200; ls_wdata = 32'hDEADBEEF;
    ls_req = 1'b1;
    tick();
    tick();
    rst = 1'b1;
    #1;
    chk_reset_outputs("t6_rst");
    ls_req = 1'b0;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    chk("t6_post_rst_no_wr", {31'd0, mem_wr}, 32'd0);

    chk("wr_queue_drained", wr_q.size(), 32'd0);
    chk("resp_queue_drained", resp_q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
